// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths.
// Config macro: UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int CLK_HZ        = 12_000_000;
    localparam int BAUD          = 300;
    // clk cycles per uart_clk period (16x oversampling): 2500 at 12 MHz / 300 baud
    localparam int DIVISOR       = CLK_HZ / (BAUD * TICKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake into the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO, power-of-two depth, wrap-bit pointers.
// Head data is read combinationally; flags come straight from registered pointers.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // a push while full or a pop while empty is silently dropped
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    // pointer registers; reset empties the buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // storage write; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8-N-1 UART transmitter timed by a 16x-baud uart_clk.
// Config macro: UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      uart_clk,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy
);
    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BIT_ONE   = 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [3:0]    LAST_TICK = 4'(TICKS_PER_BIT - 1);

    uart_tx_state_t       state_q, state_d;
    logic                 uart_clk_q, tick, bit_end, last_stop, pop;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.tx_valid),
        .wdata_i (bus.tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.tx_ready = !fifo_full;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign tx           = tx_q;

    // uart_clk is already synchronous; one register gives the rising-edge tick
    always_ff @(posedge clk) begin
        if (reset) uart_clk_q <= 1'b0;
        else       uart_clk_q <= uart_clk;
    end

    assign tick      = uart_clk && !uart_clk_q;
    assign bit_end   = tick && (tick_cnt_q == LAST_TICK);
    assign last_stop = (stop_cnt_q == LAST_STOP);

    // next state; a pop happens from IDLE or at the end of the last stop bit
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && bit_cnt_q == LAST_BIT)
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (bit_end && last_stop) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // counters and shifter; the tick counter wraps so a bit-end tick is tick 0 of the next bit
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (pop) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            shift_d    = fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^fifo_head;
`endif
        end else if (tick && state_q != ST_IDLE) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            if (bit_end && state_q == ST_DATA) begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + BIT_ONE;
            end
            if (bit_end && state_q == ST_STOP) stop_cnt_d = stop_cnt_q + 1'b1;
        end
    end

    // line level for the next cycle, from the next state so tx moves on the tick's edge
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // state, datapath and line registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx; uart_clk period is 4 clk, so one bit is 64 clk.
// Honors UART_TX_PARITY_EN (adds the parity slot and the parity scenario).
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int BITCLK = 64;

    logic clk, reset, uart_clk;
    logic tx, busy, tx2, busy2;
    int   passed, total;

    uart_tx_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_if #(.DATA_BITS(8)) bus2 ();

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .uart_clk(uart_clk), .bus(bus1), .tx(tx), .busy(busy)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .uart_clk(uart_clk), .bus(bus2), .tx(tx2), .busy(busy2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // uart_clk edges land on clk falling edges, one period = 4 clk
    initial begin
        uart_clk = 0;
        forever #20 uart_clk = ~uart_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input bit which, input logic [7:0] b, input int limit, output bit ok);
        ok = 0;
        @(negedge clk);
        if (which) begin bus2.tx_data = b; bus2.tx_valid = 1; end
        else       begin bus1.tx_data = b; bus1.tx_valid = 1; end
        for (int i = 0; i < limit; i++) begin
            if ((which ? bus2.tx_ready : bus1.tx_ready) === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        if (which) bus2.tx_valid = 0;
        else       bus1.tx_valid = 0;
    endtask

    // Line monitor: waits for a start edge, then samples every clk of every bit slot.
    // clean stays 1 only if each slot is flat for exactly 64 clk and the start slot is low.
    task automatic rx_frame(input bit which, input int nstop, input int limit,
                            output logic [7:0] d, output logic p, output logic [1:0] stp,
                            output bit clean, output int wait_cyc);
        logic s, first;
        int   nslot;
        d = '0; p = 0; stp = '0; clean = 0; wait_cyc = 0; first = 0;
        do begin
            @(negedge clk);
            wait_cyc++;
            s = which ? tx2 : tx;
        end while (s !== 1'b0 && wait_cyc < limit);
        if (s !== 1'b0) begin wait_cyc = -1; return; end
        clean = 1;
        nslot = 1 + 8 + PAR + nstop;
        for (int k = 0; k < nslot; k++) begin
            for (int j = 0; j < BITCLK; j++) begin
                if (k != 0 || j != 0) begin
                    @(negedge clk);
                    s = which ? tx2 : tx;
                end
                if (j == 0) first = s;
                else if (s !== first) clean = 0;
                if (j == 32) begin
                    if (k == 0) begin
                        if (s !== 1'b0) clean = 0;
                    end else if (k <= 8) d[k-1] = s;
                    else if (PAR == 1 && k == 9) p = s;
                    else stp[k-9-PAR] = s;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1;
        bus1.tx_valid = 0; bus1.tx_data = '0;
        bus2.tx_valid = 0; bus2.tx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
        total++; if (bus1.tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus1.tx_ready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (tx2 !== 1'b1 || busy2 !== 1'b0) $display("FAIL reset_dut2: got tx=%b busy=%b want 1/0", tx2, busy2); else passed++;
        reset = 0;
        repeat (8) @(negedge clk);
        total++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL idle_after_reset: got tx=%b busy=%b want 1/0", tx, busy); else passed++;
    endtask

    task automatic test_single;
        bit ok, cl; logic [7:0] d; logic p; logic [1:0] st; int w;
        push(0, 8'hA5, 20, ok);
        total++; if (ok !== 1'b1) $display("FAIL single_push: got %b want 1", ok); else passed++;
        rx_frame(0, 1, 40, d, p, st, cl, w);
        total++; if (!(w >= 1 && w <= 4)) $display("FAIL single_latency: got %0d want 1..4", w); else passed++;
        total++; if (d !== 8'hA5) $display("FAIL single_data: got %h want a5", d); else passed++;
        total++; if (cl !== 1'b1) $display("FAIL single_timing: got %b want 1", cl); else passed++;
        total++; if (st[0] !== 1'b1) $display("FAIL single_stop: got %b want 1", st[0]); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy_in_stop: got %b want 1", busy); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || tx !== 1'b1) $display("FAIL single_busy_fall: got busy=%b tx=%b want 0/1", busy, tx); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] d [5]; logic [1:0] st [5]; bit cl [5]; int w [5]; logic p;
        logic [7:0] exp_b [5];
        exp_b = '{8'h00, 8'hFF, 8'h55, 8'h81, 8'h99};
        fork
            begin
                // first push lands on a tick edge while empty, so no pop until the next tick
                @(posedge uart_clk);
                bus1.tx_data = 8'h00; bus1.tx_valid = 1;
                @(posedge clk); #1 bus1.tx_data = 8'hFF;
                @(posedge clk); #1 bus1.tx_data = 8'h55;
                @(posedge clk); #1 bus1.tx_data = 8'h81;
                @(posedge clk); #1;
                total++; if (bus1.tx_ready !== 1'b0) $display("FAIL b2b_full: got %b want 0", bus1.tx_ready); else passed++;
                bus1.tx_data = 8'h99;
                @(posedge clk); #1;
                total++; if (bus1.tx_ready !== 1'b1) $display("FAIL b2b_ready_after_pop: got %b want 1", bus1.tx_ready); else passed++;
                @(posedge clk); #1;
                bus1.tx_valid = 0;
                total++; if (bus1.tx_ready !== 1'b0) $display("FAIL b2b_fifth_accepted: got %b want 0", bus1.tx_ready); else passed++;
            end
            begin
                for (int i = 0; i < 5; i++) rx_frame(0, 1, (i == 0) ? 40 : 400, d[i], p, st[i], cl[i], w[i]);
            end
        join
        total++; if (w[0] <= 0) $display("FAIL b2b_first_start: got %0d want >0", w[0]); else passed++;
        for (int i = 0; i < 5; i++) begin
            total++; if (d[i] !== exp_b[i]) $display("FAIL b2b_data%0d: got %h want %h", i, d[i], exp_b[i]); else passed++;
            total++; if (cl[i] !== 1'b1 || st[i][0] !== 1'b1) $display("FAIL b2b_shape%0d: got clean=%b stop=%b want 1/1", i, cl[i], st[i][0]); else passed++;
        end
        for (int i = 1; i < 5; i++) begin
            total++; if (w[i] !== 1) $display("FAIL b2b_gap%0d: got %0d want 1", i, w[i]); else passed++;
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_stop2;
        bit ok1, ok2, cla, clb; logic [7:0] da, db; logic p; logic [1:0] sa, sb; int wa, wb;
        fork
            begin push(1, 8'h3C, 20, ok1); push(1, 8'h3C, 20, ok2); end
            begin
                rx_frame(1, 2, 40, da, p, sa, cla, wa);
                rx_frame(1, 2, 800, db, p, sb, clb, wb);
            end
        join
        total++; if (ok1 !== 1'b1 || ok2 !== 1'b1) $display("FAIL stop2_push: got %b%b want 11", ok1, ok2); else passed++;
        total++; if (da !== 8'h3C || db !== 8'h3C) $display("FAIL stop2_data: got %h %h want 3c 3c", da, db); else passed++;
        total++; if (sa !== 2'b11 || sb !== 2'b11) $display("FAIL stop2_stop_bits: got %b %b want 11 11", sa, sb); else passed++;
        total++; if (cla !== 1'b1 || clb !== 1'b1) $display("FAIL stop2_timing: got %b %b want 1 1", cla, clb); else passed++;
        total++; if (wb !== 1) $display("FAIL stop2_next_start: got %0d want 1", wb); else passed++;
        @(negedge clk);
        total++; if (busy2 !== 1'b0) $display("FAIL stop2_busy_end: got %b want 0", busy2); else passed++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        bit ok, cl; logic [7:0] d; logic p; logic [1:0] st; int w;
        fork
            push(0, 8'h07, 20, ok);
            rx_frame(0, 1, 40, d, p, st, cl, w);
        join
        total++; if (d !== 8'h07) $display("FAIL parity_data: got %h want 07", d); else passed++;
        total++; if (p !== 1'b1) $display("FAIL parity_bit: got %b want 1", p); else passed++;
        total++; if (cl !== 1'b1 || st[0] !== 1'b1) $display("FAIL parity_frame: got clean=%b stop=%b want 1/1", cl, st[0]); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL parity_busy_end: got %b want 0", busy); else passed++;
    endtask
`endif

    task automatic test_reset_mid;
        bit ok; bit seen; int zeros, busys;
        seen = 0;
        fork
            begin push(0, 8'h12, 20, ok); push(0, 8'h34, 20, ok); push(0, 8'h56, 20, ok); end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (tx === 1'b0) begin seen = 1; break; end
                end
                // centre of data bit 3 (slot 4 of the frame)
                repeat (4 * BITCLK + 32) @(negedge clk);
            end
        join
        total++; if (seen !== 1'b1) $display("FAIL rmid_start: got %b want 1", seen); else passed++;
        total++; if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL rmid_bit3: got tx=%b busy=%b want 0/1", tx, busy); else passed++;
        reset = 1;
        @(posedge clk); #1;
        total++; if (tx !== 1'b1) $display("FAIL rmid_tx: got %b want 1", tx); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
        total++; if (bus1.tx_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", bus1.tx_ready); else passed++;
        @(negedge clk);
        reset = 0;
        zeros = 0; busys = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
            if (busy !== 1'b0) busys++;
        end
        total++; if (zeros !== 0 || busys !== 0) $display("FAIL rmid_no_frame: got %0d low/%0d busy samples want 0/0", zeros, busys); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset;
        test_single;
        test_back_to_back;
        test_stop2;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
